// File: rtl/seg7_pkg.sv
// Shared types and constants for the step-by-2 seven-segment controller.
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD
   } ctrl_state_t;

   localparam int NUM_DIGITS = 4;

   // Active-low segment patterns. The bit string reads a..g from left to right,
   // so segment a is the MSB of the vector.
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001101;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern decoder.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] i_num,
   output logic [6:0] o_seg
);

   // Map one digit to its segment pattern; non-BCD codes blank the digit.
   always_comb begin
      // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
      o_seg = SEG_BLANK;
      case (i_num)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_step_ctrl.sv
// Step-by-2 parity BCD counter with run/hold/clear control and a
// four-digit multiplexed common-anode seven-segment display driver.
module seg7_step_ctrl
   import seg7_pkg::*;
#(
   parameter int STEP_DIV = 50_000_000,
   parameter int SCAN_DIV = 50_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       eo,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   output logic [6:0] led,
   output logic [3:0] an,
   output logic       running
);

   localparam int                STEP_W    = $clog2(STEP_DIV);
   localparam int                SCAN_W    = $clog2(SCAN_DIV + 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   ctrl_state_t       r_state;
   ctrl_state_t       w_next_state;
   logic [STEP_W-1:0] r_step_cnt;
   logic [SCAN_W-1:0] r_scan_cnt;
   logic [1:0]        r_sel;
   logic [1:0]        w_sel_next;
   logic [3:0]        r_an;
   logic [15:0]       r_count;
   logic [15:0]       w_count_inc;
   logic [15:0]       w_base;
   logic              w_step_tick;
   logic [3:0]        w_digit;

   // Even sequence starts at 0000, odd at 0001.
   assign w_base = {15'd0, eo};

   // Next-state decode: clear beats stop, stop beats start.
   always_comb begin
      w_next_state = r_state;
      w_step_tick  = 1'b0;
      if (clear) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (start && !stop) w_next_state = RUN;
            RUN: begin
               if (stop) w_next_state = HOLD;
               else      w_step_tick  = (r_step_cnt == STEP_LAST);
            end
            HOLD:    if (start && !stop) w_next_state = RUN;
            default: w_next_state = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // BCD add-2: ones digit gets +2, then a single carry ripples upward;
   // the carry out of the top digit is dropped, giving mod-10000 wrap.
   always_comb begin
      logic [4:0] sum;
      logic [4:0] add;
      add         = 5'd2;
      sum         = 5'd0;
      w_count_inc = r_count;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         sum = {1'b0, r_count[4*i +: 4]} + add;
         if (sum >= 5'd10) begin
            w_count_inc[4*i +: 4] = 4'(sum - 5'd10);
            add                   = 5'd1;
         end else begin
            w_count_inc[4*i +: 4] = sum[3:0];
            add                   = 5'd0;
         end
      end
   end

   // Step prescaler and count: reload in IDLE, advance in RUN, freeze in HOLD.
   always_ff @(posedge clk) begin
      if (reset || clear || (r_state == IDLE)) begin
         r_step_cnt <= '0;
         r_count    <= w_base;
      end else if ((r_state == RUN) && !stop) begin
         if (w_step_tick) begin
            r_step_cnt <= '0;
            r_count    <= w_count_inc;
         end else begin
            r_step_cnt <= r_step_cnt + STEP_W'(1);
         end
      end
   end

   assign w_sel_next = r_sel + 2'd1;

   // Scan prescaler and digit select; anode enables are registered one-cold.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scan_cnt <= '0;
         r_sel      <= 2'd0;
         r_an       <= 4'b1110;
      end else if (r_scan_cnt == SCAN_LAST) begin
         r_scan_cnt <= '0;
         r_sel      <= w_sel_next;
         r_an       <= ~(4'b0001 << w_sel_next);
      end else begin
         r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
      end
   end

   // Digit mux feeding the single shared decoder.
   always_comb begin
      w_digit = r_count[3:0];
      case (r_sel)
         2'd0: w_digit = r_count[3:0];
         2'd1: w_digit = r_count[7:4];
         2'd2: w_digit = r_count[11:8];
         2'd3: w_digit = r_count[15:12];
         default: w_digit = r_count[3:0];
      endcase
   end

   seg7_decode u_decode (
      .i_num (w_digit),
      .o_seg (led)
   );

   assign an      = r_an;
   assign running = (r_state == RUN);

endmodule

// File: tb/tb_seg7_step_ctrl.sv
// Self-checking bench for seg7_step_ctrl against an integer-arithmetic model.
module tb_seg7_step_ctrl;

   localparam int STEP_DIV = 4;
   localparam int SCAN_DIV = 1;
   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_HOLD   = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       eo = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       clear = 1'b0;
   logic [6:0] led;
   logic [3:0] an;
   logic       running;

   int total = 0;
   int bad   = 0;

   // Reference model: count is a plain integer 0..9999.
   int m_mode  = M_IDLE;
   int m_cnt   = 0;
   int m_phase = 0;
   int m_scan  = 0;
   int m_sel   = 0;

   always #5 clk = ~clk;

   seg7_step_ctrl #(
      .STEP_DIV (STEP_DIV),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .eo      (eo),
      .start   (start),
      .stop    (stop),
      .clear   (clear),
      .led     (led),
      .an      (an),
      .running (running)
   );

   function automatic logic [6:0] seg_of(int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001101;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic int digit_of(int value, int k);
      int v = value;
      for (int j = 0; j < k; j++) v = v / 10;
      return v % 10;
   endfunction

   // Expected {running, an, led} from the model.
   function automatic logic [11:0] expected();
      logic [3:0] a;
      logic       r;
      a = 4'b0001 << m_sel;
      a = ~a;
      r = (m_mode == M_RUN);
      return {r, a, seg_of(digit_of(m_cnt, m_sel))};
   endfunction

   // Advance the model by one clock using the inputs sampled at the edge.
   task automatic model_step();
      if (reset) begin
         m_mode  = M_IDLE;
         m_cnt   = int'(eo);
         m_phase = 0;
         m_scan  = 0;
         m_sel   = 0;
         return;
      end
      m_scan++;
      if (m_scan == SCAN_DIV) begin
         m_scan = 0;
         m_sel  = (m_sel + 1) % 4;
      end
      if (clear) begin
         m_mode  = M_IDLE;
         m_cnt   = int'(eo);
         m_phase = 0;
      end else begin
         case (m_mode)
            M_IDLE: begin
               m_cnt   = int'(eo);
               m_phase = 0;
               if (start && !stop) m_mode = M_RUN;
            end
            M_RUN: begin
               if (stop) m_mode = M_HOLD;
               else if (m_phase == STEP_DIV - 1) begin
                  m_phase = 0;
                  m_cnt   = (m_cnt + 2) % 10000;
               end else m_phase++;
            end
            default: if (start && !stop) m_mode = M_RUN;
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset(input logic parity);
      eo = parity; start = 1'b0; stop = 1'b0; clear = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] seeds [4];
      seeds[0] = {4'b1110, 7'b1001111};
      seeds[1] = {4'b1101, 7'b0000001};
      seeds[2] = {4'b1011, 7'b0000001};
      seeds[3] = {4'b0111, 7'b0000001};
      eo = 1'b1; reset = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 1) reset = 1'b0;
         if (i > 0) tick();
         total++;
         if ({running, an, led} !== {1'b0, seeds[i]}) begin
            bad++;
            $display("FAIL reset_seed[%0d]: got %b want %b", i, {running, an, led}, {1'b0, seeds[i]});
         end
      end
   endtask

   task automatic test_stepping();
      do_reset(1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (running !== 1'b1) begin
         bad++;
         $display("FAIL start_running: got %b want 1", running);
      end
      for (int i = 0; i < 13; i++) begin
         if (i == 5) eo = 1'b1;
         tick();
         total++;
         if ({running, an, led} !== expected()) begin
            bad++;
            $display("FAIL stepping[%0d]: got %b want %b", i, {running, an, led}, expected());
         end
      end
   endtask

   task automatic test_hold();
      int guard = 0;
      do_reset(1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      while (!(m_cnt == 4 && m_phase == 2) && guard < 200) begin
         tick();
         guard++;
      end
      total++;
      if (guard >= 200) begin
         bad++;
         $display("FAIL hold_reach: got timeout want count 4 phase 2");
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         total++;
         if ({running, an, led} !== expected()) begin
            bad++;
            $display("FAIL hold_frozen[%0d]: got %b want %b", i, {running, an, led}, expected());
         end
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if ({running, an, led} !== expected()) begin
            bad++;
            $display("FAIL hold_resume[%0d]: got %b want %b", i, {running, an, led}, expected());
         end
      end
   endtask

   task automatic test_simultaneous();
      stop = 1'b1;
      tick();
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({running, an, led} !== expected() || running !== 1'b0) begin
            bad++;
            $display("FAIL start_stop_hold[%0d]: got %b want %b", i, {running, an, led}, expected());
         end
      end
      stop = 1'b0;
      tick();
      start = 1'b0;
      total++;
      if ({running, an, led} !== expected() || running !== 1'b1) begin
         bad++;
         $display("FAIL hold_to_run: got %b want %b", {running, an, led}, expected());
      end
      eo = 1'b0; clear = 1'b1; start = 1'b1;
      tick();
      clear = 1'b0; start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         total++;
         if ({running, an, led} !== expected() || running !== 1'b0) begin
            bad++;
            $display("FAIL clear_start[%0d]: got %b want %b", i, {running, an, led}, expected());
         end
      end
   endtask

   task automatic test_midrun_reset();
      int guard = 0;
      do_reset(1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      while (m_cnt != 10 && guard < 200) begin
         tick();
         guard++;
      end
      eo = 1'b1;
      tick();
      total++;
      if ({running, an, led} !== expected()) begin
         bad++;
         $display("FAIL eo_ignored_run: got %b want %b", {running, an, led}, expected());
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if ({running, an, led} !== {1'b0, 4'b1110, 7'b1001111}) begin
         bad++;
         $display("FAIL midrun_reset: got %b want %b", {running, an, led}, {1'b0, 4'b1110, 7'b1001111});
      end
   endtask

   task automatic test_wrap(input logic parity);
      int target = parity ? 9999 : 9998;
      int guard  = 0;
      do_reset(parity);
      start = 1'b1;
      tick();
      start = 1'b0;
      while (m_cnt != target && guard < 25000) begin
         tick();
         guard++;
         if (guard % 512 == 0) begin
            total++;
            if ({running, an, led} !== expected()) begin
               bad++;
               $display("FAIL wrap_run_p%0d: got %b want %b", parity, {running, an, led}, expected());
            end
         end
      end
      if (guard >= 25000) begin
         total++;
         bad++;
         $display("FAIL wrap_timeout_p%0d: got count %0d want %0d", parity, m_cnt, target);
      end
      for (int i = 0; i < 2 * STEP_DIV + 4; i++) begin
         tick();
         total++;
         if ({running, an, led} !== expected()) begin
            bad++;
            $display("FAIL wrap_p%0d[%0d]: got %b want %b", parity, i, {running, an, led}, expected());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(255) == 0);
         clear = ($urandom_range(31) == 0);
         start = ($urandom_range(7) == 0);
         stop  = ($urandom_range(15) == 0);
         if ($urandom_range(15) == 0) eo = ~eo;
         tick();
         total++;
         if ({running, an, led} !== expected()) begin
            bad++;
            $display("FAIL random[%0d]: got %b want %b", i, {running, an, led}, expected());
         end
      end
      reset = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stepping();
      test_hold();
      test_simultaneous();
      test_midrun_reset();
      test_wrap(1'b1);
      test_wrap(1'b0);
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg7_step_ctrl.md
# seg7_step_ctrl

Sequencing and display controller for the step-by-2 parity counter. It holds a 4-digit BCD count that advances by 2 at a programmable rate, seeded even or odd by `eo`. It time-multiplexes a single seven-segment decoder across four common-anode digits. It sits between the board switches/buttons and the 7-segment display.

## Interface
Parameters:
- `STEP_DIV`, default 50_000_000: clock cycles per count step while running; must be ≥2.
- `SCAN_DIV`, default 50_000: clock cycles each digit stays selected; must be ≥1.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `eo`  in  1  parity select: 0 = even sequence (base 0000), 1 = odd sequence (base 0001).
- `start`  in  1  level, sampled each cycle; requests run.
- `stop`  in  1  level, sampled each cycle; requests hold.
- `clear`  in  1  level, sampled each cycle; returns to idle and reloads base.
- `led`  out  7  segments `[0:6]` = a..g, active-low.
- `an`  out  4  digit enables, active-low; `an[0]` = ones digit.
- `running`  out  1  high in RUN state.

## Operation
States: IDLE, RUN, HOLD.
- **IDLE:**
  - Count is reloaded with the base every cycle, so it tracks `eo`.
  - `start` → RUN, with `step_cnt` cleared to 0.
- **RUN:**
  - `step_cnt` counts 0..STEP_DIV-1.
  - On the cycle `step_cnt == STEP_DIV-1`, count advances by 2 and `step_cnt` returns to 0.
  - `stop` → HOLD.
- **HOLD:**
  - Count and `step_cnt` are frozen.
  - `start` → RUN, resuming `step_cnt` where it stopped.
- **Priority:**
  - `clear` beats `stop`, and `stop` beats `start`.
  - `clear` in any state → IDLE, with count = base and `step_cnt` = 0.
  - `start` and `stop` asserted together in IDLE or HOLD: remain in the current state.
- **`eo` changes:** ignored outside IDLE; they take effect only via IDLE.
- **BCD increment by 2:**
  - Ones digit: d0 + 2. If the result is ≥10, subtract 10 and carry 1.
  - Carry ripples through d1..d3. Each digit is 4 bits and always holds 0..9.
  - Carry out of d3 is discarded, so the count is mod 10000 and parity is preserved: 9998 → 0000, 9999 → 0001.
- **Scan:**
  - `scan_cnt` counts 0..SCAN_DIV-1 in every state.
  - At terminal count, the digit select advances 0→1→2→3→0.
  - `an` is the one-cold encoding of the digit select.
  - `led` = decode(selected digit), using these patterns:
    - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
    - 5 = 0100100, 6 = 0100000, 7 = 0001101, 8 = 0000000, 9 = 0000100
    - any other value = 1111111 (blank)
  - No leading-zero blanking.

## Timing
- **Reset (any cycle, including mid-run):** on the next edge:
  - state = IDLE, count = base per `eo` sampled that cycle;
  - `step_cnt` = 0, `scan_cnt` = 0, digit select = 0, `an` = 4'b1110, `running` = 0;
  - `led` = decode(d0), i.e. 0000001 (`eo`=0) or 1001111 (`eo`=1).
- **Registers:** state, count, counters and `an` are registered.
- **Derived outputs:**
  - `led` is combinational from the registered digit select and count; it is consistent with `an` in the same cycle.
  - `running` is decoded from state.
- **`start` latency:** `start` sampled at edge N → `running` = 1 after edge N. The first step lands at edge N+STEP_DIV.
- **`stop` latency:** `stop` at the same edge as a terminal `step_cnt` → the step is suppressed (HOLD takes effect that edge).
- **Count update:** visible on `led` the cycle after the step edge, when its digit is selected.

## Structure
- **Package `seg7_pkg`:**
  - state enum `ctrl_state_t` {IDLE, RUN, HOLD};
  - segment constants SEG_0..SEG_9 and SEG_BLANK;
  - localparam NUM_DIGITS = 4.
- **Sub-module `seg7_decode`:** 4-bit number in, 7-bit active-low pattern out, purely combinational. It is instantiated once and fed by the digit mux.
- **Top module contents:**
  - FSM;
  - step prescaler (width $clog2(STEP_DIV));
  - scan prescaler (width $clog2(SCAN_DIV+1));
  - BCD incrementer;
  - digit mux.

## Test plan
- **Reset seeding:** reset with `eo`=1, SCAN_DIV=1 → `an` cycles 1110, 1101, 1011, 0111; `led` shows 1001111, 0000001, 0000001, 0000001.
- **Stepping:** STEP_DIV=4, `eo`=0, pulse `start` → `running`=1. Count reads 0002 after 4 cycles, 0004 after 8 and 0006 after 12; `eo` toggled mid-run has no effect.
- **Wrap, both parities:**
  - preload via run from 0001 to 9999 (or a forced count), then one step → 0001, d3..d1 = 0;
  - even run from 9998 → 0000.
- **Hold:**
  - `stop` at count 0004 with `step_cnt`=2 → count frozen for 20 cycles;
  - `start` → next step after 2 more cycles → 0006.
- **Simultaneous controls:**
  - `start`+`stop` in HOLD → stays HOLD;
  - `clear`+`start` in RUN → IDLE with count 0000 (`eo`=0).
- **Mid-run reset:** `reset` asserted during RUN at count 0010 with `eo`=1 → next cycle count 0001, state IDLE, `an`=1110.
